// File: rtl/verinject_fault_scheduler_pkg.sv
// Shared types and constants for the verinject fault-injection scheduler.
package verinject_pkg;

  localparam int CYCLE_W_DEF = 32;

  // Broadcast value meaning "no injection this cycle".
  localparam logic [31:0] INJ_STATE_NONE = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // One scheduled injection at the default counter width.
  typedef struct packed {
    logic [CYCLE_W_DEF-1:0] cycle;
    logic [31:0]            state;
  } sched_entry_t;

endpackage

// File: rtl/verinject_fault_scheduler_if.sv
// Control, load and status bundle between a campaign driver and the scheduler.
interface verinject_fault_scheduler_if #(
  parameter int DEPTH   = 8,
  parameter int CYCLE_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               start;
  logic               abort;
  logic               load_valid;
  logic               load_ready;
  logic [CYCLE_W-1:0] load_cycle;
  logic [31:0]        load_state;
  logic [31:0]        verinject__injector_state;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   pending;
  logic [CYCLE_W-1:0] cycle_count;
  logic               order_err;
  logic               timeout_err;

  // The campaign driver side.
  modport master (
    output start, abort, load_valid, load_cycle, load_state,
    input  load_ready, verinject__injector_state, busy, done, pending,
           cycle_count, order_err, timeout_err
  );

  // The scheduler side.
  modport slave (
    input  start, abort, load_valid, load_cycle, load_state,
    output load_ready, verinject__injector_state, busy, done, pending,
           cycle_count, order_err, timeout_err
  );
endinterface

// File: rtl/verinject_fault_scheduler_fifo.sv
// Synchronous FIFO holding pending injection entries; head is visible combinationally.
module verinject_sched_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Pointer and occupancy tracking; a flush empties the FIFO and overrides push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clock) begin
    if (w_doPush && !i_flush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/verinject_fault_scheduler.sv
// Campaign sequencer: counts campaign cycles and broadcasts each queued injector
// state for exactly one cycle when its trigger cycle is reached.
module verinject_fault_scheduler
  import verinject_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int CYCLE_W = 32
) (
  input logic                        clock,
  input logic                        reset,
  verinject_fault_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CYCLE_W-1:0] CYCLE_MAX    = {CYCLE_W{1'b1}};
  localparam logic [CYCLE_W-1:0] CYCLE_PRESAT = CYCLE_MAX - CYCLE_W'(1);

  typedef struct packed {
    logic [CYCLE_W-1:0] cycle;
    logic [31:0]        state;
  } entry_t;

  sched_state_t       r_state;
  sched_state_t       w_stateNext;
  logic [CYCLE_W-1:0] r_count;
  logic [CYCLE_W-1:0] w_countNext;
  logic [31:0]        r_inj;
  logic [31:0]        w_injNext;
  logic               r_orderErr;
  logic               w_orderErrNext;
  logic               r_timeoutErr;
  logic               w_timeoutErrNext;
  logic [CYCLE_W-1:0] r_lastCycle;
  logic [CYCLE_W-1:0] w_lastCycleNext;
  logic               r_lastValid;
  logic               w_lastValidNext;

  entry_t             w_head;
  entry_t             w_pushEntry;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_fifoCount;
  logic               w_push;
  logic               w_pop;
  logic               w_flush;
  logic               w_loadReady;
  logic               w_handshake;
  logic               w_loadOk;
  logic               w_fire;
  logic               w_nonEmptyAfter;

  // A load handshake completes whenever ready; the entry is stored only if it
  // keeps the list strictly time-ordered and still lies in the future.
  assign w_loadReady = !w_full && (r_state != DONE) && !bus.abort;
  assign w_handshake = bus.load_valid && w_loadReady;
  assign w_loadOk    = (bus.load_state != INJ_STATE_NONE)
                    && (!r_lastValid || (bus.load_cycle > r_lastCycle))
                    && ((r_state != RUN) || (bus.load_cycle > r_count));
  assign w_push      = w_handshake && w_loadOk;
  assign w_pushEntry = '{cycle: bus.load_cycle, state: bus.load_state};

  assign w_fire = (r_state == RUN) && !w_empty && (w_head.cycle == r_count);
  assign w_pop  = w_fire;

  // True when entries will remain queued after this edge's push/pop.
  assign w_nonEmptyAfter = w_push ||
                           (!w_empty && !(w_pop && (w_fifoCount == CNT_W'(1))));

  verinject_sched_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_pushEntry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifoCount)
  );

  // Next-state logic: abort dominates, then start/run sequencing, then load bookkeeping.
  always_comb begin
    w_stateNext      = r_state;
    w_countNext      = r_count;
    w_injNext        = INJ_STATE_NONE;
    w_orderErrNext   = r_orderErr;
    w_timeoutErrNext = r_timeoutErr;
    w_lastCycleNext  = r_lastCycle;
    w_lastValidNext  = r_lastValid;
    w_flush          = 1'b0;

    if (bus.abort) begin
      w_stateNext     = IDLE;
      w_flush         = 1'b1;
      w_lastValidNext = 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            w_stateNext      = RUN;
            w_countNext      = '0;
            w_orderErrNext   = 1'b0;
            w_timeoutErrNext = 1'b0;
          end
        end
        RUN: begin
          if (w_fire) w_injNext = w_head.state;
          if (r_count != CYCLE_MAX) w_countNext = r_count + CYCLE_W'(1);
          if ((r_count == CYCLE_PRESAT) && w_nonEmptyAfter) begin
            w_stateNext      = DONE;
            w_flush          = 1'b1;
            w_timeoutErrNext = 1'b1;
          end else if (w_empty || !w_nonEmptyAfter) begin
            w_stateNext = DONE;
          end
        end
        default: w_stateNext = IDLE;
      endcase

      if (w_handshake) begin
        if (w_loadOk) begin
          w_lastCycleNext = bus.load_cycle;
          w_lastValidNext = 1'b1;
        end else begin
          w_orderErrNext = 1'b1;
        end
      end
    end
  end

  // State, counter, broadcast and sticky-flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_inj        <= INJ_STATE_NONE;
      r_orderErr   <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_lastCycle  <= '0;
      r_lastValid  <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_count      <= w_countNext;
      r_inj        <= w_injNext;
      r_orderErr   <= w_orderErrNext;
      r_timeoutErr <= w_timeoutErrNext;
      r_lastCycle  <= w_lastCycleNext;
      r_lastValid  <= w_lastValidNext;
    end
  end

  assign bus.load_ready                = w_loadReady;
  assign bus.verinject__injector_state = r_inj;
  assign bus.busy                      = (r_state == RUN);
  assign bus.done                      = (r_state == DONE);
  assign bus.pending                   = w_fifoCount;
  assign bus.cycle_count               = r_count;
  assign bus.order_err                 = r_orderErr;
  assign bus.timeout_err               = r_timeoutErr;

endmodule

// File: tb/tb_verinject_fault_scheduler.sv
// Self-checking bench for the fault scheduler, using a queue-based campaign model.
module tb_verinject_fault_scheduler;
  localparam int DEPTH   = 4;
  localparam int CYCLE_W = 5;
  localparam int MAXC    = (1 << CYCLE_W) - 1;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DONE  = 2;

  logic clock = 1'b0;
  logic reset;

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  verinject_fault_scheduler_if #(.DEPTH(DEPTH), .CYCLE_W(CYCLE_W)) bus ();

  verinject_fault_scheduler #(.DEPTH(DEPTH), .CYCLE_W(CYCLE_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model of the campaign.
  int          mState;
  int          mCyc[$];
  logic [31:0] mSt[$];
  int          mCount;
  logic [31:0] mInj;
  bit          mOrd;
  bit          mTo;
  bit          mLastValid;
  int          mLast;

  int checkCount = 0;
  int errorCount = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mState = M_IDLE;
    mCyc.delete();
    mSt.delete();
    mCount = 0;
    mInj = 32'h0;
    mOrd = 1'b0;
    mTo = 1'b0;
    mLastValid = 1'b0;
    mLast = 0;
  endtask

  // Advance the model by one clock edge given the inputs presented before it.
  task automatic modelEdge(input bit st, input bit ab, input bit hs, input int lc,
                           input logic [31:0] ls);
    bit ok;
    int preSize;
    int oldCount;
    if (ab) begin
      mState = M_IDLE;
      mCyc.delete();
      mSt.delete();
      mInj = 32'h0;
      mLastValid = 1'b0;
      return;
    end
    ok = hs && (ls != 32'h0) && (!mLastValid || lc > mLast) &&
         (mState != M_RUN || lc > mCount);
    preSize = mCyc.size();
    mInj = 32'h0;
    if (mState == M_RUN) begin
      if (preSize > 0 && mCyc[0] == mCount) begin
        mInj = mSt[0];
        void'(mCyc.pop_front());
        void'(mSt.pop_front());
      end
      if (ok) begin
        mCyc.push_back(lc);
        mSt.push_back(ls);
      end
      oldCount = mCount;
      if (mCount < MAXC) mCount++;
      if (oldCount == MAXC - 1 && mCyc.size() > 0) begin
        mCyc.delete();
        mSt.delete();
        mTo = 1'b1;
        mState = M_DONE;
      end else if (preSize == 0 || mCyc.size() == 0) begin
        mState = M_DONE;
      end
    end else begin
      if (st) begin
        mState = M_RUN;
        mCount = 0;
        mOrd = 1'b0;
        mTo = 1'b0;
      end
      if (ok) begin
        mCyc.push_back(lc);
        mSt.push_back(ls);
      end
    end
    if (hs && !ok) mOrd = 1'b1;
    if (ok) begin
      mLast = lc;
      mLastValid = 1'b1;
    end
  endtask

  task automatic compareAll();
    checkOutput("injector_state", bus.verinject__injector_state, mInj);
    checkOutput("busy", bus.busy, (mState == M_RUN));
    checkOutput("done", bus.done, (mState == M_DONE));
    checkOutput("pending", bus.pending, mCyc.size());
    checkOutput("cycle_count", bus.cycle_count, mCount);
    checkOutput("order_err", bus.order_err, mOrd);
    checkOutput("timeout_err", bus.timeout_err, mTo);
  endtask

  // One full cycle: drive inputs, check ready, take the edge, check all outputs.
  task automatic applyStimulus(input bit st, input bit ab, input bit lv, input int lc,
                               input logic [31:0] ls);
    bit expReady;
    bit hs;
    bus.start      = st;
    bus.abort      = ab;
    bus.load_valid = lv;
    bus.load_cycle = lc[CYCLE_W-1:0];
    bus.load_state = ls;
    #1;
    expReady = (mCyc.size() < DEPTH) && (mState != M_DONE) && !ab;
    checkOutput("load_ready", bus.load_ready, expReady);
    hs = lv && expReady;
    @(posedge clock);
    modelEdge(st, ab, hs, lc, ls);
    #1;
    compareAll();
  endtask

  task automatic loadEntry(input int lc, input logic [31:0] ls);
    applyStimulus(1'b0, 1'b0, 1'b1, lc, ls);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic startCampaign();
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic abortCampaign();
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 32'h0);
  endtask

  // Guard against a stuck run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized campaign mix.
  initial begin
    int   lc;
    int   base;
    bit   st;
    bit   ab;
    bit   lv;
    logic [31:0] ls;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_cycle = '0;
    bus.load_state = 32'h0;
    modelReset();
    #2;
    compareAll();
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] two spaced injections");
    loadEntry(5, 32'h1);
    loadEntry(9, 32'h2);
    startCampaign();
    idleCycles(14);
    abortCampaign();

    $display("[TB] back-to-back injections");
    loadEntry(3, 32'hA);
    loadEntry(4, 32'hB);
    startCampaign();
    idleCycles(8);
    abortCampaign();

    $display("[TB] ordering and zero-state rejection");
    loadEntry(7, 32'h11);
    loadEntry(7, 32'h22);
    loadEntry(2, 32'h33);
    loadEntry(8, 32'h0);
    abortCampaign();

    $display("[TB] full list and push during fire");
    loadEntry(2, 32'h100);
    loadEntry(3, 32'h200);
    loadEntry(4, 32'h300);
    loadEntry(5, 32'h400);
    loadEntry(6, 32'h500);
    startCampaign();
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0, 1'b1, 10 + k, 32'h600 + k);
    idleCycles(14);
    abortCampaign();

    $display("[TB] abort mid-campaign");
    loadEntry(6, 32'h7);
    loadEntry(8, 32'h8);
    loadEntry(10, 32'h9);
    startCampaign();
    idleCycles(2);
    abortCampaign();
    idleCycles(12);

    $display("[TB] counter saturation");
    loadEntry(30, 32'hC0DE);
    loadEntry(31, 32'hBEEF);
    startCampaign();
    idleCycles(34);
    startCampaign();
    idleCycles(2);
    abortCampaign();

    $display("[TB] asynchronous reset mid-campaign");
    loadEntry(14, 32'h5A5A);
    startCampaign();
    idleCycles(16);
    loadEntry(20, 32'h1234);
    abortCampaign();
    loadEntry(20, 32'h1234);
    startCampaign();
    idleCycles(5);
    reset = 1'b1;
    #1;
    modelReset();
    compareAll();
    @(posedge clock);
    #1;
    compareAll();
    reset = 1'b0;

    $display("[TB] randomized campaigns");
    for (int n = 0; n < 3000; n++) begin
      st = ($urandom_range(0, 19) == 0);
      ab = ($urandom_range(0, 79) == 0);
      lv = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) begin
        lc = $urandom_range(0, MAXC);
      end else begin
        base = mLastValid ? mLast + 1 : 0;
        if (mState == M_RUN && mCount + 1 > base) base = mCount + 1;
        lc = base + $urandom_range(0, 3);
        if (lc > MAXC) lc = $urandom_range(0, MAXC);
      end
      ls = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom() | 32'h1);
      applyStimulus(st, ab, lv, lc, ls);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
